// File: rtl/dual_grant_scheduler.sv
// Two-channel grant scheduler: shares two identical slots among N_REQ requesters.
// Optional round-robin search order is enabled by defining DUAL_GRANT_RR_EN.
module dual_grant_scheduler #(
  parameter int N_REQ = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             rel_1,
  input  logic             rel_2,
  output logic [3:0]       gnt_1_id,
  output logic [3:0]       gnt_2_id,
  output logic             gnt_1_vld,
  output logic             gnt_2_vld,
  output logic [N_REQ-1:0] gnt_vec
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } ch_state_e;

  ch_state_e        st1_q, st1_d, st2_q, st2_d;
  logic [3:0]       id1_q, id1_d, id2_q, id2_d;
  logic [N_REQ-1:0] vec_q, vec_d;
  logic [N_REQ-1:0] cand;
  logic [4:0]       hi, lo;
  logic [3:0]       p_cur;
  logic             rel1_now, rel2_now;

`ifdef DUAL_GRANT_RR_EN
  logic [3:0] p_q, p_d;
  assign p_cur = p_q;
`else
  assign p_cur = 4'(N_REQ - 1);
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [3:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Owner code -> vector bit; code 0 means nobody.
  function automatic logic [N_REQ-1:0] code_vec(input logic [3:0] code);
    if (code == 4'd0) return '0;
    return onehot(code - 4'd1);
  endfunction

  // Search downward from start with wrap; returns {found, index}.
  function automatic logic [4:0] pick(input logic [N_REQ-1:0] c, input logic [3:0] start);
    logic       found;
    logic [3:0] sel;
    int         i;
    found = 1'b0;
    sel   = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      i = int'(start) - k;
      if (i < 0) i = i + N_REQ;
      if (!found && c[i[3:0]]) begin
        found = 1'b1;
        sel   = i[3:0];
      end
    end
    return {found, sel};
  endfunction

`ifdef DUAL_GRANT_RR_EN
  function automatic logic [3:0] wrap_dec(input logic [3:0] idx);
    if (idx == 4'd0) return 4'(N_REQ - 1);
    return idx - 4'd1;
  endfunction
`endif

  always_comb begin
    st1_d = st1_q;
    st2_d = st2_q;
    id1_d = id1_q;
    id2_d = id2_q;
`ifdef DUAL_GRANT_RR_EN
    p_d   = p_q;
`endif
    cand     = req & ~vec_q;
    hi       = pick(cand, p_cur);
    lo       = pick(cand & ~onehot(hi[3:0]), p_cur);
    rel1_now = (st1_q == OWNED) && (rel_1 || ((req & code_vec(id1_q)) == '0));
    rel2_now = (st2_q == OWNED) && (rel_2 || ((req & code_vec(id2_q)) == '0));

    // A releasing channel is still OWNED this cycle, so it never regrants on the same edge.
    if (rel1_now) begin
      st1_d = IDLE;
      id1_d = 4'd0;
    end
    if (rel2_now) begin
      st2_d = IDLE;
      id2_d = 4'd0;
    end

    if (st1_q == IDLE && st2_q == IDLE) begin
      if (hi[4]) begin
        st1_d = OWNED;
        id1_d = hi[3:0] + 4'd1;
      end
      if (lo[4]) begin
        st2_d = OWNED;
        id2_d = lo[3:0] + 4'd1;
      end
    end else if (st1_q == IDLE) begin
      if (hi[4]) begin
        st1_d = OWNED;
        id1_d = hi[3:0] + 4'd1;
      end
    end else if (st2_q == IDLE) begin
      if (hi[4]) begin
        st2_d = OWNED;
        id2_d = hi[3:0] + 4'd1;
      end
    end

    vec_d = code_vec(id1_d) | code_vec(id2_d);

`ifdef DUAL_GRANT_RR_EN
    // Pointer moves just below the lowest-priority index granted on this edge.
    if (st2_q == IDLE && st2_d == OWNED)
      p_d = wrap_dec(id2_d - 4'd1);
    else if (st1_q == IDLE && st1_d == OWNED)
      p_d = wrap_dec(id1_d - 4'd1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_q <= IDLE;
      st2_q <= IDLE;
      id1_q <= 4'd0;
      id2_q <= 4'd0;
      vec_q <= '0;
`ifdef DUAL_GRANT_RR_EN
      p_q   <= 4'(N_REQ - 1);
`endif
    end else begin
      st1_q <= st1_d;
      st2_q <= st2_d;
      id1_q <= id1_d;
      id2_q <= id2_d;
      vec_q <= vec_d;
`ifdef DUAL_GRANT_RR_EN
      p_q   <= p_d;
`endif
    end
  end

  assign gnt_1_id  = id1_q;
  assign gnt_2_id  = id2_q;
  assign gnt_1_vld = (st1_q == OWNED);
  assign gnt_2_vld = (st2_q == OWNED);
  assign gnt_vec   = vec_q;

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Directed bench for dual_grant_scheduler; round-robin expectations follow DUAL_GRANT_RR_EN.
module tb_dual_grant_scheduler;

  logic        clk;
  logic        reset;
  logic [11:0] req;
  logic        rel_1, rel_2;
  logic [3:0]  gnt_1_id, gnt_2_id;
  logic        gnt_1_vld, gnt_2_vld;
  logic [11:0] gnt_vec;

  int n_cmp;
  int n_err;

  dual_grant_scheduler #(.N_REQ(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rel_1     (rel_1),
    .rel_2     (rel_2),
    .gnt_1_id  (gnt_1_id),
    .gnt_2_id  (gnt_2_id),
    .gnt_1_vld (gnt_1_vld),
    .gnt_2_vld (gnt_2_vld),
    .gnt_vec   (gnt_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                         input logic v1, input logic v2, input logic [11:0] ev);
    chk({tag, ".id1"}, {12'd0, gnt_1_id}, {12'd0, e1});
    chk({tag, ".id2"}, {12'd0, gnt_2_id}, {12'd0, e2});
    chk({tag, ".vld1"}, {15'd0, gnt_1_vld}, {15'd0, v1});
    chk({tag, ".vld2"}, {15'd0, gnt_2_vld}, {15'd0, v2});
    chk({tag, ".vec"}, {4'd0, gnt_vec}, {4'd0, ev});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e1;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 12'h000;
    rel_1 = 1'b0;
    rel_2 = 1'b0;
    #2;
    chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step();
    chk_all("idle5", 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);

    rel_1 = 1'b1;
    step();
    rel_1 = 1'b0;
    chk_all("rel_idle", 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);

    req = 12'h801;
    step();
    chk_all("grant801", 4'd12, 4'd1, 1'b1, 1'b1, 12'h801);
    step();
    chk_all("hold801", 4'd12, 4'd1, 1'b1, 1'b1, 12'h801);

    req   = 12'h821;
    rel_2 = 1'b1;
    step();
    rel_2 = 1'b0;
    chk_all("rel2", 4'd12, 4'd0, 1'b1, 1'b0, 12'h800);
    step();
    chk_all("regrant6", 4'd12, 4'd6, 1'b1, 1'b1, 12'h820);

    req = 12'h028;
    step();
    chk_all("drop11", 4'd0, 4'd6, 1'b0, 1'b1, 12'h020);
    step();
    chk_all("grant4", 4'd4, 4'd6, 1'b1, 1'b1, 12'h028);

    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);
    step();
    reset = 1'b0;
    req   = 12'h0C0;
    step();
    chk_all("grant0C0", 4'd8, 4'd7, 1'b1, 1'b1, 12'h0C0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 12'hFFF;
    for (int k = 0; k < 7; k++) begin
      step();
`ifdef DUAL_GRANT_RR_EN
      e1 = 4'(12 - 2 * (k % 6));
`else
      e1 = 4'd12;
`endif
      chk_all($sformatf("rr_pair%0d", k), e1, e1 - 4'd1, 1'b1, 1'b1,
              (12'h001 << (e1 - 4'd1)) | (12'h001 << (e1 - 4'd2)));
      rel_1 = 1'b1;
      rel_2 = 1'b1;
      step();
      rel_1 = 1'b0;
      rel_2 = 1'b0;
      chk_all($sformatf("rr_rel%0d", k), 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
